// File: rtl/ikbd_serial_rx_if.sv
// Byte-stream handshake between the IKBD serial receiver and the host-side ACIA model.
// The master drives the byte and its valid flag. The slave drives ready.
interface ikbd_serial_rx_if;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/ikbd_serial_rx.sv
// 8N1 receiver for the HD63701 SCI transmit line. It oversamples the line on the MCU clock
// and buffers the received bytes in a small FIFO that drives a valid/ready output.
module ikbd_serial_rx #(
    parameter int CLKS_PER_BIT = 512,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    rxd,
    ikbd_serial_rx_if.master        host,
    output logic                    frame_err,
    output logic                    overrun,
    input  logic                    err_clr,
    output logic                    busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 8 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks_per_bit
        $error("CLKS_PER_BIT must be even and at least 8");
    end
    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizer and start arming
    // ------------------------------------------------------------------
    logic       sync1;
    logic       rxs;
    logic [1:0] warm;
    logic       armed;

    // The synchronizer resets to 1, so rxs only carries a real line sample two clocks
    // after reset. The receiver is armed by the first real high sample. A frame that
    // is already in progress at reset is therefore picked up at its next falling edge.
    // NOTE: every clocked register uses non-blocking assignment so each flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (res) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            warm  <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
            warm  <= {warm[0], 1'b1};
            if (warm[1] && rxs) begin
                armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          push_req;
    logic          frame_err_nx;

    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        bit_idx_nx   = bit_idx;
        shreg_nx     = shreg;
        push_req     = 1'b0;
        frame_err_nx = 1'b0;

        case (state)
            IDLE: begin
                if (armed && !rxs) begin
                    cnt_nx   = CNT_HALF;
                    state_nx = START;
                end
            end

            START: begin
                if (cnt == '0) begin
                    if (!rxs) begin
                        cnt_nx     = CNT_BIT;
                        bit_idx_nx = 3'd0;
                        state_nx   = DATA;
                    end else begin
                        state_nx   = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end

            DATA: begin
                if (cnt == '0) begin
                    shreg_nx   = {rxs, shreg[7:1]};
                    cnt_nx     = CNT_BIT;
                    bit_idx_nx = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end

            STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                if (cnt == '0) begin
                    push_req     = rxs;
                    frame_err_nx = !rxs;
                    state_nx     = IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_idx   <= bit_idx_nx;
            shreg     <= shreg_nx;
            frame_err <= frame_err_nx;
        end
    end

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && host.dout_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO can still take the byte.
    assign push  = push_req && (!full || pop);

    // NOTE: the storage is reset as well, so dout reads a defined 8'h00 while the FIFO is empty after reset.
    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= shreg;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            overrun <= (push_req && full && !pop) || (overrun && !err_clr);
        end
    end

    assign host.dout       = mem[rd_ptr[AW-1:0]];
    assign host.dout_valid = !empty;

endmodule

// File: doc/ikbd_serial_rx.md
# ikbd_serial_rx

Receives the IKBD microcontroller's SCI transmit line and turns it into a byte stream for the host-side ACIA model. The line is the serial TX bit of the HD63701's port 2 output, 8N1 at 7812.5 baud. The block sits directly downstream of the MCU on the keyboard-to-host path. It oversamples the line with the MCU's own clock, frames bytes, and buffers them in a small FIFO with a valid/ready output handshake.

## Interface
- `CLKS_PER_BIT`, default 512: clk cycles per bit (N). Must be even and ≥ 8.
- `FIFO_DEPTH`, default 4: byte buffer entries. Must be a power of two, ≥ 2.
- `clk` in 1: the MCU's CLKx2 clock. Single clock domain.
- `res` in 1: synchronous, active-high reset.
- `rxd` in 1: serial line from MCU port 2 TX. Idle high. Asynchronous to clk.
- `dout` out 8: byte at the FIFO head.
- `dout_valid` out 1: FIFO is non-empty.
- `dout_ready` in 1: consumer accepts. A pop happens when `dout_valid && dout_ready`.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: sticky; set when a received byte is dropped because the FIFO is full.
- `err_clr` in 1: clears `overrun`.
- `busy` out 1: the FSM is not in IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer. Its reset value is 1. Call the synchronized line `rxs`.
- Let H = N/2.
- FSM states:
  - IDLE: if `rxs` == 0, load the counter with H-1 and go to START.
  - START: at counter 0, sample `rxs`. If 0, load N-1, set bit index to 0, go to DATA. If 1 (glitch), go to IDLE with no output.
  - DATA: at counter 0, shift `rxs` into the shift register, LSB first, and reload N-1. After bit 7, go to STOP.
  - STOP: at counter 0, sample `rxs`. If 1, push the shift register into the FIFO. If 0, pulse `frame_err` and discard the byte. Go to IDLE in the same cycle either way.
- Returning to IDLE at mid-stop-bit means a back-to-back start edge is caught without loss.
- FIFO: wr_ptr and rd_ptr are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH.
  - Empty when the pointers are equal. Full when the MSBs differ and the rest are equal.
  - `dout` is combinational from the head entry and holds stable while `dout_valid && !dout_ready`.
- Push when full and no pop in the same cycle: drop the byte and set `overrun`. FIFO contents are unchanged.
- Push when full with a pop in the same cycle: both happen, the new byte is stored, and `overrun` is not set.
- Push and pop in the same cycle when non-full: level is unchanged.
- `err_clr` in the same cycle as a new overrun event: set wins.
- `res` mid-frame: the FSM goes to IDLE, the FIFO empties, the flags clear, and the partial byte is lost. After release, a frame already in progress on `rxd` is picked up only at its next high→low transition.

## Timing
- Reset values: `dout_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, `dout`=8'h00. All FIFO storage resets to 0.
- Cycle 0 is the first clk edge that samples `rxd`=0 into sync flop 1. `rxs` is low from cycle 2.
- Start check at cycle 2+H.
- Data bit i sampled at cycle 2+H+(i+1)·N.
- Stop bit sampled at cycle 2+H+9N.
- `dout_valid` rises at cycle 3+H+9N if the FIFO was empty. For N=512 that is cycle 4867.
- `frame_err` is high for exactly cycle 3+H+9N.
- Minimum low pulse on `rxd` that is accepted as a start bit: H+1 cycles. Shorter pulses are rejected.
- Full throughput is one byte per 10N cycles with no gaps.

## Test plan
- N=16, send 0xA5 (line low, 1,0,1,0,0,1,0,1, high) with `dout_ready`=1 → `dout`=0xA5 and `dout_valid` high for exactly 1 cycle at cycle 3+8+144=155. `frame_err`=0.
- N=16, `rxd` low for 3 cycles then high → no push. `busy` returns to 0 at cycle 10. FIFO stays empty.
- N=16, send 0x3C with the stop bit driven 0 → `frame_err` pulses once at cycle 155, `dout_valid` stays 0, `overrun` stays 0.
- N=16, depth 4, `dout_ready`=0, send 0x01..0x05 back-to-back → `overrun`=1 after the fifth stop bit. Then raise `dout_ready` → reads 0x01, 0x02, 0x03, 0x04, then `dout_valid`=0. Then `err_clr` → `overrun`=0.
- N=16, FIFO full with 0x11..0x14, `dout_ready`=1 in exactly the stop-sample cycle of 0x15 → pop and push both occur, `overrun`=0, subsequent reads 0x12, 0x13, 0x14, 0x15.
- N=16, assert `res` for 1 cycle during data bit 4 of 0x77 → all outputs return to reset values next cycle. No byte is pushed. A following frame 0x5A is received correctly.
